// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler feeding one UART transmitter from two
// requesters (A: one byte, B: two bytes LSB first), with ACK timeout re-issue.
module uart_tx_sched #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [2*DATA_WIDTH-1:0] b_data,
  output logic                    b_ready,
  input  logic                    tx_busy,
  output logic                    tx_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    sched_busy,
  output logic                    ack_err
);

  localparam int unsigned WW = 2 * DATA_WIDTH;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = 2;
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  // rr_ptr: 0 = A wins the next tie, 1 = B wins the next tie
  logic            rr_ptr, rr_nxt;
  logic [LW-1:0]   left, left_nxt;
  logic [CW-1:0]   to_cnt, to_nxt;
  logic [WW-1:0]   data_q, data_nxt;
  logic            a_ready_nxt, b_ready_nxt, tx_valid_nxt, ack_err_nxt, sched_busy_nxt;
  logic [DATA_WIDTH-1:0] tx_data_nxt;
  logic            grant_b;

  // State, context and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      left       <= '0;
      to_cnt     <= '0;
      data_q     <= '0;
      a_ready    <= 1'b0;
      b_ready    <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      sched_busy <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      left       <= left_nxt;
      to_cnt     <= to_nxt;
      data_q     <= data_nxt;
      a_ready    <= a_ready_nxt;
      b_ready    <= b_ready_nxt;
      tx_valid   <= tx_valid_nxt;
      tx_data    <= tx_data_nxt;
      sched_busy <= sched_busy_nxt;
      ack_err    <= ack_err_nxt;
    end
  end

  // Next-state, arbitration and next-output logic
  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr_ptr;
    left_nxt     = left;
    to_nxt       = to_cnt;
    data_nxt     = data_q;
    a_ready_nxt  = 1'b0;
    b_ready_nxt  = 1'b0;
    tx_valid_nxt = 1'b0;
    ack_err_nxt  = 1'b0;
    tx_data_nxt  = tx_data;
    grant_b      = b_valid && (!a_valid || rr_ptr);

    unique case (state)
      IDLE: begin
        if (a_valid || b_valid) begin
          if (grant_b) begin
            data_nxt    = b_data;
            left_nxt    = LW'(2);
            b_ready_nxt = 1'b1;
            rr_nxt      = 1'b0;
          end else begin
            data_nxt    = WW'(a_data);
            left_nxt    = LW'(1);
            a_ready_nxt = 1'b1;
            rr_nxt      = 1'b1;
          end
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // transmitter may still be shifting out an unrelated byte
        if (!tx_busy) state_nxt = ISSUE;
      end
      ISSUE: begin
        tx_data_nxt  = data_q[DATA_WIDTH-1:0];
        tx_valid_nxt = 1'b1;
        to_nxt       = '0;
        state_nxt    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          ack_err_nxt = 1'b1;
          state_nxt   = ISSUE;
        end else begin
          to_nxt = to_cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          left_nxt = left - LW'(1);
          if (left_nxt != '0) begin
            data_nxt  = data_q >> DATA_WIDTH;
            state_nxt = GRANT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    sched_busy_nxt = (state_nxt != IDLE);
  end

endmodule
